// File: rtl/pwm_decoder.sv
// pwm_decoder
//   Receive-side decoder for the 16-slot PWM generator. Samples an
//   asynchronous PWM line on the 3.125 MHz system clock and measures, for
//   every period between two successive rising edges, the high time and the
//   period length. It then reports the recovered 4-bit duty code. A line
//   with no rising edge for TIMEOUT cycles (stuck high or stuck low) is
//   reported as duty 0 with the timeout level set.
//
// Parameters
//   CNT_W    width of the high-time and period counters
//   TIMEOUT  cycles without a rising edge before the line is declared stuck
//            (16 < TIMEOUT < 2**CNT_W)
//
// Ports
//   clk_3125KHz  in   system clock; all logic runs on the rising edge
//   rst_n        in   synchronous active-low reset
//   pwm_in       in   asynchronous PWM line
//   duty_cycle   out  recovered duty code, min(high_time, 15)
//   high_time    out  high cycles in the last completed period
//   period       out  total cycles in the last completed period
//   valid        out  one-cycle strobe: the outputs were updated this cycle
//   period_err   out  last measurement had a period other than 16
//   timeout      out  level: no rising edge seen for TIMEOUT cycles
module pwm_decoder #(
  parameter int CNT_W   = 8,
  parameter int TIMEOUT = 64
) (
  input  logic             clk_3125KHz,
  input  logic             rst_n,
  input  logic             pwm_in,
  output logic [3:0]       duty_cycle,
  output logic [CNT_W-1:0] high_time,
  output logic [CNT_W-1:0] period,
  output logic             valid,
  output logic             period_err,
  output logic             timeout
);

  typedef enum logic {
    IDLE    = 1'b0,
    MEASURE = 1'b1
  } state_e;

  localparam logic [CNT_W-1:0] CNT_ZERO   = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE    = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_MAX    = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] TIMEOUT_C  = CNT_W'(TIMEOUT);
  localparam logic [CNT_W-1:0] PERIOD_NOM = CNT_W'(16);
  localparam logic [CNT_W-1:0] DUTY_MAX   = CNT_W'(15);

  // Saturating increment: the counters stick at all-ones instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v,
                                               input logic             en);
    logic [CNT_W-1:0] r;
    if (en && (v != CNT_MAX)) begin
      r = v + CNT_ONE;
    end else begin
      r = v;
    end
    return r;
  endfunction

  // Clamp a high-time count to the 4-bit duty code.
  function automatic logic [3:0] duty_of(input logic [CNT_W-1:0] h);
    logic [3:0] r;
    if (h > DUTY_MAX) begin
      r = 4'hF;
    end else begin
      r = h[3:0];
    end
    return r;
  endfunction

  logic             s1_q, s2_q, s3_q;
  logic             rise_s;
  state_e           state_q, state_d;
  logic [CNT_W-1:0] per_cnt_q, per_cnt_d;
  logic [CNT_W-1:0] high_cnt_q, high_cnt_d;
  logic [3:0]       duty_q, duty_d;
  logic [CNT_W-1:0] high_time_q, high_time_d;
  logic [CNT_W-1:0] period_q, period_d;
  logic             valid_q, valid_d;
  logic             period_err_q, period_err_d;
  logic             timeout_q, timeout_d;

  // Synchronizer and history flop. They reset to 1, so a line that is
  // already high when reset is released is not seen as a rising edge.
  always_ff @(posedge clk_3125KHz) begin
    if (!rst_n) begin
      s1_q <= 1'b1;
      s2_q <= 1'b1;
      s3_q <= 1'b1;
    end else begin
      s1_q <= pwm_in;
      s2_q <= s1_q;
      s3_q <= s2_q;
    end
  end

  assign rise_s = s2_q & ~s3_q;

  // Next-state logic for the measurement FSM, its counters and the output
  // registers.
  always_comb begin
    state_d      = state_q;
    per_cnt_d    = per_cnt_q;
    high_cnt_d   = high_cnt_q;
    duty_d       = duty_q;
    high_time_d  = high_time_q;
    period_d     = period_q;
    valid_d      = 1'b0;
    period_err_d = period_err_q;
    timeout_d    = timeout_q;
    case (state_q)
      IDLE: begin
        if (rise_s) begin
          state_d    = MEASURE;
          per_cnt_d  = CNT_ONE;
          high_cnt_d = CNT_ONE;
        end else begin
          state_d = IDLE;
        end
      end
      MEASURE: begin
        if (rise_s) begin
          // A rise closes the period. It wins over a coincident timeout.
          // The report uses the counts as they stood before this cycle's
          // update, and the rise cycle itself starts the next period at 1.
          period_d     = per_cnt_q;
          high_time_d  = high_cnt_q;
          duty_d       = duty_of(high_cnt_q);
          period_err_d = (per_cnt_q != PERIOD_NOM);
          timeout_d    = 1'b0;
          valid_d      = 1'b1;
          per_cnt_d    = CNT_ONE;
          high_cnt_d   = CNT_ONE;
        end else if (per_cnt_q == TIMEOUT_C) begin
          period_d     = CNT_ZERO;
          high_time_d  = CNT_ZERO;
          duty_d       = 4'd0;
          period_err_d = 1'b0;
          timeout_d    = 1'b1;
          valid_d      = 1'b1;
          per_cnt_d    = CNT_ZERO;
          high_cnt_d   = CNT_ZERO;
          state_d      = IDLE;
        end else begin
          per_cnt_d  = sat_inc(per_cnt_q, 1'b1);
          high_cnt_d = sat_inc(high_cnt_q, s2_q);
        end
      end
      default: begin
        state_d    = IDLE;
        per_cnt_d  = CNT_ZERO;
        high_cnt_d = CNT_ZERO;
      end
    endcase
  end

  // State, counter and output registers.
  always_ff @(posedge clk_3125KHz) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      per_cnt_q    <= CNT_ZERO;
      high_cnt_q   <= CNT_ZERO;
      duty_q       <= 4'd0;
      high_time_q  <= CNT_ZERO;
      period_q     <= CNT_ZERO;
      valid_q      <= 1'b0;
      period_err_q <= 1'b0;
      timeout_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      per_cnt_q    <= per_cnt_d;
      high_cnt_q   <= high_cnt_d;
      duty_q       <= duty_d;
      high_time_q  <= high_time_d;
      period_q     <= period_d;
      valid_q      <= valid_d;
      period_err_q <= period_err_d;
      timeout_q    <= timeout_d;
    end
  end

  assign duty_cycle = duty_q;
  assign high_time  = high_time_q;
  assign period     = period_q;
  assign valid      = valid_q;
  assign period_err = period_err_q;
  assign timeout    = timeout_q;

endmodule

// File: tb/tb_pwm_decoder.sv
// tb_pwm_decoder
//   Drives PWM waveforms described by a table of {high cycles, low cycles,
//   repeats, expected report} rows. The expected report for each period is
//   queued when the rising edge that closes that period is driven. A monitor
//   pops one entry per valid strobe and compares it. Hand-written sequences
//   cover the stuck-line timeout, its recovery, and reset in mid-period.
module tb_pwm_decoder;

  logic       clk_3125KHz;
  logic       rst_n;
  logic       pwm_in;
  logic [3:0] duty_cycle;
  logic [7:0] high_time;
  logic [7:0] period;
  logic       valid;
  logic       period_err;
  logic       timeout;

  pwm_decoder #(.CNT_W(8), .TIMEOUT(64)) dut (
    .clk_3125KHz (clk_3125KHz),
    .rst_n       (rst_n),
    .pwm_in      (pwm_in),
    .duty_cycle  (duty_cycle),
    .high_time   (high_time),
    .period      (period),
    .valid       (valid),
    .period_err  (period_err),
    .timeout     (timeout)
  );

  // 320 ns period, i.e. 3.125 MHz.
  initial clk_3125KHz = 1'b0;
  always #160 clk_3125KHz = ~clk_3125KHz;

  typedef struct packed {
    logic [3:0] duty;
    logic [7:0] ht;
    logic [7:0] per;
    logic       perr;
    logic       to;
  } exp_t;

  typedef struct {
    int         h;
    int         l;
    int         reps;
    logic [7:0] exp_high;
    logic [7:0] exp_per;
    logic [3:0] exp_duty;
    logic       exp_perr;
  } vec_t;

  vec_t tbl[9];
  exp_t sb_q[$];
  exp_t prev_e;
  exp_t to_e;
  bit   in_stream;
  int   vectors;
  int   miscompares;
  int   cyc;
  int   last_valid_cyc;
  int   prev_valid_cyc;

  task automatic check(input string name, input logic [31:0] got,
                       input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  function automatic exp_t row_exp(input vec_t v);
    exp_t e;
    e = '{v.exp_duty, v.exp_high, v.exp_per, v.exp_perr, 1'b0};
    return e;
  endfunction

  // Called at a falling edge: one period of h high and l low cycles. The
  // rising edge closes the previous period of the stream, so that period's
  // report is queued now.
  task automatic drive_period(input int h, input int l, input exp_t e);
    pwm_in = 1'b1;
    if (in_stream) sb_q.push_back(prev_e);
    prev_e    = e;
    in_stream = 1'b1;
    repeat (h) @(negedge clk_3125KHz);
    pwm_in = 1'b0;
    repeat (l) @(negedge clk_3125KHz);
  endtask

  // The line is held low. The open period never closes, so a timeout
  // report is expected instead.
  task automatic hold_low(input int n);
    pwm_in = 1'b0;
    sb_q.push_back(to_e);
    in_stream = 1'b0;
    repeat (n) @(negedge clk_3125KHz);
  endtask

  initial begin
    exp_t got;
    exp_t e;
    vectors        = 0;
    miscompares    = 0;
    cyc            = 0;
    last_valid_cyc = 0;
    prev_valid_cyc = 0;
    in_stream      = 1'b0;
    to_e           = '{4'd0, 8'd0, 8'd0, 1'b0, 1'b1};
    prev_e         = to_e;

    tbl[0] = '{8,  8,  4, 8'd8,  8'd16, 4'd8,  1'b0};
    tbl[1] = '{1,  15, 3, 8'd1,  8'd16, 4'd1,  1'b0};
    tbl[2] = '{15, 1,  3, 8'd15, 8'd16, 4'd15, 1'b0};
    tbl[3] = '{5,  15, 3, 8'd5,  8'd20, 4'd5,  1'b1};
    tbl[4] = '{20, 4,  3, 8'd20, 8'd24, 4'd15, 1'b1};
    tbl[5] = '{3,  13, 3, 8'd3,  8'd16, 4'd3,  1'b0};
    tbl[6] = '{3,  5,  1, 8'd3,  8'd8,  4'd3,  1'b1};   // code change mid-period
    tbl[7] = '{12, 4,  3, 8'd12, 8'd16, 4'd12, 1'b0};
    tbl[8] = '{5,  11, 3, 8'd5,  8'd16, 4'd5,  1'b0};

    fork
      forever begin
        @(posedge clk_3125KHz);
        cyc++;
      end
      forever begin
        @(negedge clk_3125KHz);
        if (valid === 1'b1) begin
          got = '{duty_cycle, high_time, period, period_err, timeout};
          if (sb_q.size() == 0) begin
            check("unexpected_valid", 32'(got), 32'h1FFFFF);
          end else begin
            e = sb_q.pop_front();
            check("report", 32'(got), 32'(e));
          end
          prev_valid_cyc = last_valid_cyc;
          last_valid_cyc = cyc;
        end
      end
    join_none

    // Reset state.
    rst_n  = 1'b0;
    pwm_in = 1'b0;
    repeat (3) @(negedge clk_3125KHz);
    check("rst_valid", 32'(valid), 32'd0);
    check("rst_duty", 32'(duty_cycle), 32'd0);
    check("rst_high", 32'(high_time), 32'd0);
    check("rst_period", 32'(period), 32'd0);
    check("rst_perr", 32'(period_err), 32'd0);
    check("rst_timeout", 32'(timeout), 32'd0);
    rst_n = 1'b1;
    @(negedge clk_3125KHz);

    // Table-driven stream: code 8, 1, 15, 5/20, 20/4, 3, mixed, 12, 5.
    for (int r = 0; r < 9; r++) begin
      for (int k = 0; k < tbl[r].reps; k++) begin
        drive_period(tbl[r].h, tbl[r].l, row_exp(tbl[r]));
      end
    end

    // Line stuck low after the code-5 stream.
    hold_low(100);
    check("timeout_gap", 32'(last_valid_cyc - prev_valid_cyc), 32'd64);
    check("timeout_level", 32'(timeout), 32'd1);
    check("timeout_drained", 32'(sb_q.size()), 32'd0);

    // Restore code 5: timeout stays set until the second new rise.
    drive_period(5, 11, row_exp(tbl[8]));
    check("timeout_held", 32'(timeout), 32'd1);
    drive_period(5, 11, row_exp(tbl[8]));
    drive_period(5, 11, row_exp(tbl[8]));
    check("timeout_cleared", 32'(timeout), 32'd0);

    // Reset for one cycle mid-period with the line high.
    pwm_in = 1'b1;
    sb_q.push_back(prev_e);
    in_stream = 1'b0;
    repeat (4) @(negedge clk_3125KHz);
    rst_n = 1'b0;
    @(negedge clk_3125KHz);
    check("mrst_valid", 32'(valid), 32'd0);
    check("mrst_duty", 32'(duty_cycle), 32'd0);
    check("mrst_high", 32'(high_time), 32'd0);
    check("mrst_period", 32'(period), 32'd0);
    check("mrst_perr", 32'(period_err), 32'd0);
    check("mrst_timeout", 32'(timeout), 32'd0);
    rst_n = 1'b1;
    repeat (3) @(negedge clk_3125KHz);
    pwm_in = 1'b0;
    repeat (10) @(negedge clk_3125KHz);
    for (int k = 0; k < 3; k++) begin
      drive_period(tbl[0].h, tbl[0].l, row_exp(tbl[0]));
    end
    hold_low(100);
    check("final_drained", 32'(sb_q.size()), 32'd0);
    check("final_timeout", 32'(timeout), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
